alu_scheduler: RTL and testbench
================================

# alu_scheduler

Two-requester scheduler and sequencer for the shared 8-bit ALU and ripple adder datapath. It arbitrates round-robin between two operation requesters and drives the ALU operand and select lines for the required number of cycles. It captures the ALU result and returns it on a single response channel with backpressure. It also implements an 8-bit multiply (low byte) as a shift-add sequence of ALU add passes, so the adder needs no multiplier.

## Interface

Parameters:

- ALU_LAT, default 1: cycles from stable alu_a/alu_b/alu_select to a valid alu_y. Legal range 1..4.

Ports (clock and reset first):

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle when valid is also high.
- req0_op / req1_op  in  4  ALU select code; 4'b1111 = MUL.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the response (0/1).
- rsp_y  out  8  result.
- alu_a, alu_b  out  8  ALU operands.
- alu_select  out  4  ALU operation select.
- alu_y  in  8  ALU result.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, EXEC, MUL, RESP.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so req0 wins the first contention.

IDLE:

- Arbitration is combinational. If only one valid is high, that requester gets ready=1. If both are high, the requester with id ≠ last_grant gets ready=1.
- At most one ready is high per cycle. Both readys are 0 outside IDLE.
- On accept, latch op, a, b and id.
  - op ≠ 1111: go to EXEC.
  - op = 1111 and b ≠ 0: go to MUL, with acc=0, m=a, q=b.
  - op = 1111 and b = 0: go to RESP with y=0.

EXEC:

- Drive alu_a=a, alu_b=b, alu_select=op for ALU_LAT cycles, counted by a down-counter.
- On the last cycle, capture alu_y into y and go to RESP.

MUL step:

- If q[0]=1: drive alu_a=acc, alu_b=m, alu_select=0000 for ALU_LAT cycles, then acc ← alu_y.
- If q[0]=0: the step takes 1 cycle and the ALU is not driven.
- At step end: m ← m<<1 (truncated to 8 bits), q ← q>>1.
- If the new q = 0: y ← acc (including this step's update) and go to RESP.
- The result is the low 8 bits of a×b. Carries are discarded.

RESP:

- rsp_valid=1. rsp_id and rsp_y are held stable until rsp_ready=1.
- On handshake: last_grant ← id, go to IDLE.

Other rules:

- alu_a, alu_b and alu_select are 0 whenever the ALU is not being driven (IDLE, RESP, and q[0]=0 steps).
- Requester inputs are ignored outside IDLE. A request held valid waits with no loss.
- Reset mid-operation aborts immediately: no response is issued, and outputs and last_grant return to their reset values.

## Timing

- Request accepted at cycle T (valid and ready both high at the edge).
- Non-MUL: ALU driven T+1..T+ALU_LAT; rsp_valid first high at T+ALU_LAT+1. With ALU_LAT=1 that is T+2.
- MUL with b=0: rsp_valid at T+1.
- MUL with b≠0: steps run from T+1, with duration = ALU_LAT × popcount(b) + count of zero bits below the MSB of b. rsp_valid is high the cycle after the final step.
  - Example: b=5, ALU_LAT=1 gives steps at T+1, T+2, T+3 and rsp_valid at T+4.
- Response handshake at cycle R returns to IDLE at R+1. The earliest next accept is R+1.
- Throughput with ALU_LAT=1 and rsp_ready always high: one non-MUL op per 3 cycles.
- A new accept is never possible in the same cycle as a response handshake.

## Test plan

- Reset: assert reset mid-cycle → all outputs 0, busy=0. After release, req0/req1 both valid → req0_ready=1 first.
- Single ADD, ALU_LAT=1: req0 op=0000, a=0x12, b=0x34 accepted at T → alu_select=0000 at T+1; rsp_valid at T+2 with rsp_y=0x46, rsp_id=0.
- Contention: both valid continuously with ADD ops → grants alternate 0,1,0,1. Each rsp_id matches the accepted requester; no ready while busy=1.
- Backpressure: rsp_ready low for 3 cycles after rsp_valid → rsp_y/rsp_id stable and no new accept. Raising rsp_ready gives a handshake, then IDLE next cycle.
- MUL: a=3, b=5, ALU_LAT=1 → rsp_y=15 at T+4. a=20, b=20 → rsp_y=0x90. b=0 → rsp_y=0 at T+1. Repeat 3×5 with ALU_LAT=3 → rsp_valid at T+8.
- Reset mid-MUL: assert during step 2 of 20×20 → no rsp_valid. After release, a new ADD completes normally with req0 winning contention.

Source files
------------

// File: rtl/alu_scheduler.sv
// Round-robin scheduler for two ALU requesters. It sequences multi-cycle ALU passes,
// runs multiply as shift-and-add passes, and returns results on one backpressured response channel.
module alu_scheduler #(
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_op,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_op,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_y,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_select,
   input  logic [7:0] alu_y,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   localparam logic [3:0] OP_MUL   = 4'b1111;
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

   state_t     state;
   logic       last_grant;
   logic [1:0] cnt;
   logic [7:0] acc;
   logic [7:0] m;
   logic [7:0] q;

   logic       grant0;
   logic       grant1;
   logic       accept;
   logic       pick;
   logic [3:0] pick_op;
   logic [7:0] pick_a;
   logic [7:0] pick_b;

   logic       step_done;
   logic [7:0] acc_new;
   logic [7:0] m_new;
   logic [7:0] q_new;

   // Requester arbitration: a lone requester wins, contention goes to the one not served last.
   always_comb begin
      grant0     = req0_valid && (!req1_valid || last_grant);
      grant1     = req1_valid && (!req0_valid || !last_grant);
      req0_ready = (state == IDLE) && !reset && grant0;
      req1_ready = (state == IDLE) && !reset && grant1;
      accept     = req0_ready || req1_ready;
      pick       = req1_ready;
      if (pick) begin
         pick_op = req1_op;
         pick_a  = req1_a;
         pick_b  = req1_b;
      end else begin
         pick_op = req0_op;
         pick_a  = req0_a;
         pick_b  = req0_b;
      end
   end

   // Multiply step: the ALU computes acc + m when the current multiplier bit is set.
   always_comb begin
      step_done = 1'b0;
      acc_new   = acc;
      if (q[0]) begin
         if (cnt == 2'd0) begin
            step_done = 1'b1;
            acc_new   = alu_y;
         end else begin
            step_done = 1'b0;
         end
      end else begin
         step_done = 1'b1;
      end
      m_new = {m[6:0], 1'b0};
      q_new = {1'b0, q[7:1]};
   end

   // Sequencer FSM with registered ALU drive and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= 2'd0;
         acc        <= 8'd0;
         m          <= 8'd0;
         q          <= 8'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_y      <= 8'd0;
         alu_a      <= 8'd0;
         alu_b      <= 8'd0;
         alu_select <= 4'd0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_id <= pick;
                  busy   <= 1'b1;
                  cnt    <= CNT_INIT;
                  if (pick_op != OP_MUL) begin
                     state      <= EXEC;
                     alu_a      <= pick_a;
                     alu_b      <= pick_b;
                     alu_select <= pick_op;
                  end else if (pick_b != 8'd0) begin
                     state <= MUL;
                     acc   <= 8'd0;
                     m     <= pick_a;
                     q     <= pick_b;
                     if (pick_b[0]) begin
                        alu_a      <= 8'd0;
                        alu_b      <= pick_a;
                        alu_select <= OP_ADD;
                     end else begin
                        alu_a      <= 8'd0;
                        alu_b      <= 8'd0;
                        alu_select <= 4'd0;
                     end
                  end else begin
                     state     <= RESP;
                     rsp_y     <= 8'd0;
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            EXEC: begin
               if (cnt == 2'd0) begin
                  state      <= RESP;
                  rsp_y      <= alu_y;
                  rsp_valid  <= 1'b1;
                  alu_a      <= 8'd0;
                  alu_b      <= 8'd0;
                  alu_select <= 4'd0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            MUL: begin
               if (step_done) begin
                  acc <= acc_new;
                  m   <= m_new;
                  q   <= q_new;
                  cnt <= CNT_INIT;
                  if (q_new == 8'd0) begin
                     state      <= RESP;
                     rsp_y      <= acc_new;
                     rsp_valid  <= 1'b1;
                     alu_a      <= 8'd0;
                     alu_b      <= 8'd0;
                     alu_select <= 4'd0;
                  end else if (q_new[0]) begin
                     alu_a      <= acc_new;
                     alu_b      <= m_new;
                     alu_select <= OP_ADD;
                  end else begin
                     alu_a      <= 8'd0;
                     alu_b      <= 8'd0;
                     alu_select <= 4'd0;
                  end
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state      <= IDLE;
                  rsp_valid  <= 1'b0;
                  busy       <= 1'b0;
                  last_grant <= rsp_id;
               end else begin
                  state <= RESP;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: directed requests push expected responses,
// and a negedge monitor pops and checks them at every response handshake.
module tb_alu_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
   logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
   logic       rsp_valid, rsp_id, busy;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_y, alu_a, alu_b, alu_y;
   logic [3:0] alu_select;

   logic       x_req0_valid = 1'b0;
   logic       x_req0_ready, x_req1_ready;
   logic [3:0] x_req0_op = 4'd0;
   logic [7:0] x_req0_a = 8'd0, x_req0_b = 8'd0;
   logic       x_rsp_valid, x_rsp_id, x_busy;
   logic       x_rsp_ready = 1'b1;
   logic [7:0] x_rsp_y, x_alu_a, x_alu_b, x_alu_y;
   logic [3:0] x_alu_select;
   logic [7:0] pipe1 = 8'd0, pipe2 = 8'd0;

   typedef struct {
      logic       id;
      logic [7:0] y;
      int         lat;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rise_cyc = 0;
   logic prev_v = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         default: return a;
      endcase
   endfunction

   assign alu_y = alu_f(alu_select, alu_a, alu_b);

   // Three-cycle ALU for the second instance: result appears in the third driven cycle.
   always @(posedge clk) begin
      pipe1 <= alu_f(x_alu_select, x_alu_a, x_alu_b);
      pipe2 <= pipe1;
   end
   assign x_alu_y = pipe2;

   alu_scheduler #(.ALU_LAT(1)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_y(alu_y), .busy(busy)
   );

   alu_scheduler #(.ALU_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_op(x_req0_op), .req0_a(x_req0_a), .req0_b(x_req0_b),
      .req1_valid(1'b0), .req1_ready(x_req1_ready), .req1_op(4'd0), .req1_a(8'd0), .req1_b(8'd0),
      .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_id(x_rsp_id), .rsp_y(x_rsp_y),
      .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_select(x_alu_select), .alu_y(x_alu_y), .busy(x_busy)
   );

   task automatic chk(input bit ok, input string name, input string detail);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // Monitor: tracks accept and rsp_valid rise cycles, checks every handshake against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
         if (rsp_valid && !prev_v) rise_cyc = cyc;
         prev_v = rsp_valid;
         chk(!(req0_ready && req1_ready) && !(busy && (req0_ready || req1_ready)), "ready_excl",
             $sformatf("got r0=%0b r1=%0b busy=%0b, want one ready at most and none while busy",
                       req0_ready, req1_ready, busy));
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_rsp", $sformatf("got id=%0d y=%h, want no response", rsp_id, rsp_y));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk(rsp_id == e.id && rsp_y == e.y && (rise_cyc - acc_cyc) == e.lat, "rsp",
                   $sformatf("got id=%0d y=%h lat=%0d, want id=%0d y=%h lat=%0d",
                             rsp_id, rsp_y, rise_cyc - acc_cyc, e.id, e.y, e.lat));
            end
         end
      end
   end

   task automatic issue(input logic rid, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ey, input int elat, input bit push);
      int n = 0;
      bit got = 1'b0;
      if (rid) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      while (!got && n < 50) begin
         @(negedge clk);
         if (rid ? req1_ready : req0_ready) begin
            got = 1'b1;
            if (push) sb.push_back('{rid, ey, elat});
         end
         @(posedge clk); #1;
         n++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk(got, "accept", $sformatf("got no accept for requester %0d, want accept", rid));
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(!busy, "idle_timeout", $sformatf("got busy=%0b, want 0", busy));
      @(posedge clk); #1;
   endtask

   // Both requesters valid continuously: req0 ADD 1+2=3, req1 XOR 0F^3C=33.
   task automatic contend(input int n, input logic first);
      logic exp_id = first;
      int k = 0;
      int guard = 0;
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 8'h0F; req1_b = 8'h3C;
      while (k < n && guard < 100) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            chk(req1_ready == exp_id, "grant_order",
                $sformatf("got grant %0d, want %0d", req1_ready, exp_id));
            sb.push_back('{req1_ready, req1_ready ? 8'h33 : 8'h03, 2});
            exp_id = ~exp_id;
            k++;
         end
         @(posedge clk); #1;
         guard++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk(k == n, "contend_timeout", $sformatf("got %0d grants, want %0d", k, n));
   endtask

   initial begin
      int n;
      int hits;
      bit got;

      @(negedge clk);
      chk({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, alu_a, alu_b, alu_select, busy} == 33'd0,
          "reset_outputs", $sformatf("got busy=%0b rsp_valid=%0b alu_sel=%h, want all 0", busy, rsp_valid, alu_select));
      @(posedge clk); #1;
      reset = 1'b0;

      // First contention after reset goes to req0.
      contend(1, 1'b0);
      wait_idle();

      // Single ADD from req0; ALU drive visible in the cycle after accept.
      issue(1'b0, 4'b0000, 8'h12, 8'h34, 8'h46, 2, 1'b1);
      @(negedge clk);
      chk(alu_select == 4'b0000 && alu_a == 8'h12 && alu_b == 8'h34, "add_drive",
          $sformatf("got sel=%h a=%h b=%h, want 0/12/34", alu_select, alu_a, alu_b));
      wait_idle();

      issue(1'b1, 4'b0001, 8'h50, 8'h60, 8'hF0, 2, 1'b1);
      wait_idle();
      contend(4, 1'b0);
      wait_idle();

      // Backpressure: OR result held through 3 stalled cycles with req1 waiting.
      rsp_ready = 1'b0;
      issue(1'b0, 4'b0011, 8'h0F, 8'hA0, 8'hAF, 2, 1'b1);
      req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 8'h01; req1_b = 8'h01;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         chk(rsp_valid && rsp_y == 8'hAF && rsp_id == 1'b0 && !req1_ready, "backpressure_hold",
             $sformatf("got v=%0b y=%h id=%0d r1=%0b, want 1/AF/0/0", rsp_valid, rsp_y, rsp_id, req1_ready));
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk(!busy && !rsp_valid, "return_idle", $sformatf("got busy=%0b v=%0b, want 0/0", busy, rsp_valid));
      @(posedge clk); #1;

      // Multiply cases.
      issue(1'b0, 4'b1111, 8'd3, 8'd5, 8'd15, 4, 1'b1);
      wait_idle();
      issue(1'b0, 4'b1111, 8'd20, 8'd20, 8'h90, 6, 1'b1);
      wait_idle();
      issue(1'b1, 4'b1111, 8'h77, 8'd0, 8'd0, 1, 1'b1);
      wait_idle();

      // 3x5 with a three-cycle ALU: response 8 cycles after accept.
      x_req0_valid = 1'b1; x_req0_op = 4'b1111; x_req0_a = 8'd3; x_req0_b = 8'd5;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (x_req0_ready) got = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      x_req0_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!x_rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(got && n == 8 && x_rsp_y == 8'd15, "mul_lat3",
          $sformatf("got accept=%0b lat=%0d y=%0d, want 1/8/15", got, n, x_rsp_y));
      @(posedge clk); #1;

      // Reset during step 2 of 20x20 aborts with no response.
      issue(1'b0, 4'b1111, 8'd20, 8'd20, 8'h00, 0, 1'b0);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, alu_a, alu_b, alu_select, busy} == 33'd0,
          "reset_mid_mul", $sformatf("got busy=%0b rsp_valid=%0b alu_a=%h, want all 0", busy, rsp_valid, alu_a));
      @(posedge clk); #1;
      reset = 1'b0;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) hits++;
      end
      chk(hits == 0, "no_rsp_after_abort", $sformatf("got %0d rsp_valid cycles, want 0", hits));
      @(posedge clk); #1;
      contend(1, 1'b0);
      wait_idle();

      chk(sb.size() == 0, "scoreboard_empty", $sformatf("got %0d pending, want 0", sb.size()));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
